// File: rtl/wbd_copy_dma_if.sv
// AXI4-lite bus bundle for the copy DMA: the DMA is the master, the shared memory is the slave.
interface wbd_copy_dma_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/wbd_copy_dma.sv
// Word-by-word AXI4-lite block copy engine: read one word, write it, await the response, repeat.
// Exactly one transaction is outstanding at any time; reads and writes never overlap.
module wbd_copy_dma #(
  parameter int         LEN_W = 16,
  parameter logic [2:0] PROT  = 3'b000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  wbd_copy_dma_if.master     mem_axi
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             busy_q, done_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = mem_axi.arvalid & mem_axi.arready;
  assign r_hs  = mem_axi.rvalid  & mem_axi.rready;
  assign aw_hs = mem_axi.awvalid & mem_axi.awready;
  assign w_hs  = mem_axi.wvalid  & mem_axi.wready;
  assign b_hs  = mem_axi.bvalid  & mem_axi.bready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      busy_q    <= (state_d == S_AR) || (state_d == S_R) || (state_d == S_W) || (state_d == S_B);
      // done trails entry into FIN by one cycle, so busy has already fallen when it fires
      done_q    <= (state_q == S_FIN);
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src_addr & ~32'h3;
            dst_d   = dst_addr & ~32'h3;
            cnt_d   = len;
            state_d = S_AR;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_AR: if (ar_hs) state_d = S_R;
      S_R: begin
        if (r_hs) begin
          data_d  = mem_axi.rdata;
          state_d = S_W;
        end
      end
      S_W: begin
        // address and data channels complete independently, in either order
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (b_hs) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_FIN : S_AR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_axi.arvalid = (state_q == S_AR);
    mem_axi.araddr  = src_q;
    mem_axi.arprot  = PROT;
    mem_axi.rready  = (state_q == S_R);
    mem_axi.awvalid = (state_q == S_W) && !aw_done_q;
    mem_axi.awaddr  = dst_q;
    mem_axi.awprot  = PROT;
    mem_axi.wvalid  = (state_q == S_W) && !w_done_q;
    mem_axi.wdata   = data_q;
    mem_axi.wstrb   = 4'b1111;
    mem_axi.bready  = (state_q == S_B);
    busy            = busy_q;
    done            = done_q;
  end

endmodule

// File: tb/tb_wbd_copy_dma.sv
// Bench for wbd_copy_dma: memory-backed AXI4-lite slave with optional stalls plus a copy-level model.
module tb_wbd_copy_dma;

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done;

  always #5 clk = ~clk;

  wbd_copy_dma_if mem_axi();

  wbd_copy_dma #(.LEN_W(16), .PROT(3'b000)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src), .dst_addr(dst),
    .len(len), .busy(busy), .done(done), .mem_axi(mem_axi)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  logic [31:0] wdmem [256];
  logic [31:0] wkmem [256];

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_rd [$];
  wr_t         exp_wr [$];
  int          remaining = 0;
  int          done_cd   = 0;
  int          done_cnt  = 0;
  int          wr_cnt    = 0;
  logic        exp_busy  = 1'b0;
  logic        stall_en  = 1'b0;

  logic        hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;
  logic        prev_arvalid = 0, prev_awvalid = 0, prev_wvalid = 0;
  logic [31:0] prev_araddr = 0, prev_awaddr = 0, prev_wdata = 0;
  logic [31:0] rd_addr = 0, wa = 0, wd = 0;
  int          ar_cnt = -1, aw_cnt = -1, w_cnt = -1, b_cnt = -1, r_cnt = 0;
  logic        r_pend = 0, aw_got = 0, w_got = 0;
  wr_t         e;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chkb(input string n, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a[31:10] == 22'h0C0000) || (a[31:10] == 22'h100000);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a[31:10] == 22'h0C0000) ? wdmem[a[9:2]] : wkmem[a[9:2]];
  endfunction

  function automatic int dly();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Copy-level model: destination word i receives source word i; one write per word.
  task automatic model_launch(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da;
    sa = s & ~32'h3;
    da = d & ~32'h3;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(sa + 32'(4 * i));
      exp_wr.push_back('{a: da + 32'(4 * i), d: mem_rd(sa + 32'(4 * i))});
    end
    remaining = n;
    if (n == 0) done_cd = 2;
    else        exp_busy = 1'b1;
  endtask

  // Slave responder and per-cycle checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      mem_axi.arready = 0; mem_axi.rvalid = 0; mem_axi.rdata = 0;
      mem_axi.awready = 0; mem_axi.wready = 0; mem_axi.bvalid = 0;
      ar_cnt = -1; aw_cnt = -1; w_cnt = -1; b_cnt = -1; r_cnt = 0;
      r_pend = 0; aw_got = 0; w_got = 0;
      hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
      prev_arvalid = 0; prev_awvalid = 0; prev_wvalid = 0;
      exp_rd.delete(); exp_wr.delete();
      remaining = 0; exp_busy = 0; done_cd = 0;
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_done", done, 1'b0);
      chkb("rst_arvalid", mem_axi.arvalid, 1'b0);
      chkb("rst_awvalid", mem_axi.awvalid, 1'b0);
      chkb("rst_wvalid", mem_axi.wvalid, 1'b0);
    end else begin
      if (hs_ar) begin
        chkb("ar_expected_at_hs", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) chk("araddr", prev_araddr, exp_rd.pop_front());
        rd_addr = prev_araddr; r_pend = 1; r_cnt = dly();
        mem_axi.arready = 0; ar_cnt = -1;
      end
      if (hs_r) mem_axi.rvalid = 0;
      if (hs_aw) begin aw_got = 1; wa = prev_awaddr; mem_axi.awready = 0; aw_cnt = -1; end
      if (hs_w)  begin w_got = 1;  wd = prev_wdata;  mem_axi.wready = 0;  w_cnt = -1;  end
      if (hs_b) begin
        mem_axi.bvalid = 0; b_cnt = -1; aw_got = 0; w_got = 0; wr_cnt++;
        chkb("wr_addr_in_range", in_rng(wa), 1'b1);
        if (in_rng(wa)) begin
          if (wa[31:10] == 22'h0C0000) wdmem[wa[9:2]] = wd;
          else                         wkmem[wa[9:2]] = wd;
        end
        chkb("write_expected", exp_wr.size() > 0, 1'b1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("awaddr", wa, e.a);
          chk("wdata", wd, e.d);
        end
        remaining--;
        if (remaining == 0) begin exp_busy = 0; done_cd = 2; end
      end

      chkb("busy", busy, exp_busy);
      chkb("done", done, done_cd == 1);
      if (done_cd > 0) done_cd--;
      if (done) done_cnt++;
      if (prev_arvalid && !hs_ar) begin
        chkb("arvalid_hold", mem_axi.arvalid, 1'b1);
        chk("araddr_hold", mem_axi.araddr, prev_araddr);
      end
      if (prev_awvalid && !hs_aw) begin
        chkb("awvalid_hold", mem_axi.awvalid, 1'b1);
        chk("awaddr_hold", mem_axi.awaddr, prev_awaddr);
      end
      if (prev_wvalid && !hs_w) begin
        chkb("wvalid_hold", mem_axi.wvalid, 1'b1);
        chk("wdata_hold", mem_axi.wdata, prev_wdata);
      end
      if (mem_axi.arvalid) begin
        chkb("ar_expected", exp_rd.size() > 0, 1'b1);
        chk("arprot", 32'(mem_axi.arprot), 32'h0);
      end
      if (mem_axi.awvalid) begin
        chkb("aw_expected", exp_wr.size() > 0, 1'b1);
        chk("awprot", 32'(mem_axi.awprot), 32'h0);
      end
      if (mem_axi.wvalid) chk("wstrb", 32'(mem_axi.wstrb), 32'hF);

      if (mem_axi.arvalid && !mem_axi.arready) begin
        if (ar_cnt < 0) ar_cnt = dly();
        if (ar_cnt == 0) mem_axi.arready = 1; else ar_cnt--;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          r_pend = 0; mem_axi.rvalid = 1;
          chkb("rd_addr_in_range", in_rng(rd_addr), 1'b1);
          mem_axi.rdata = in_rng(rd_addr) ? mem_rd(rd_addr) : 32'h0;
        end else r_cnt--;
      end
      if (mem_axi.awvalid && !mem_axi.awready) begin
        if (aw_cnt < 0) aw_cnt = dly();
        if (aw_cnt == 0) mem_axi.awready = 1; else aw_cnt--;
      end
      if (mem_axi.wvalid && !mem_axi.wready) begin
        if (w_cnt < 0) w_cnt = dly();
        if (w_cnt == 0) mem_axi.wready = 1; else w_cnt--;
      end
      if (aw_got && w_got && !mem_axi.bvalid) begin
        if (b_cnt < 0) b_cnt = dly();
        if (b_cnt == 0) mem_axi.bvalid = 1; else b_cnt--;
      end

      hs_ar = mem_axi.arvalid && mem_axi.arready;
      hs_r  = mem_axi.rvalid  && mem_axi.rready;
      hs_aw = mem_axi.awvalid && mem_axi.awready;
      hs_w  = mem_axi.wvalid  && mem_axi.wready;
      hs_b  = mem_axi.bvalid  && mem_axi.bready;
      prev_arvalid = mem_axi.arvalid; prev_araddr = mem_axi.araddr;
      prev_awvalid = mem_axi.awvalid; prev_awaddr = mem_axi.awaddr;
      prev_wvalid  = mem_axi.wvalid;  prev_wdata  = mem_axi.wdata;
    end
  end

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    @(posedge clk); #1;
    start = 1; src = s; dst = d; len = 16'(n);
    @(posedge clk); #1;
    start = 0;
    model_launch(s, d, n);
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    @(posedge clk); #1;
    start = 1; src = s; dst = d; len = 16'(n);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge clk);
    chk("done_within_budget", 32'(done_cnt - d0), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, w0, i;
    resetn = 0; start = 0; src = 0; dst = 0; len = 0;
    for (int k = 0; k < 256; k++) begin
      wdmem[k] = 32'h1000_0000 | 32'(k);
      wkmem[k] = 32'hFFFF_0000 | 32'(k);
    end
    wdmem[0] = 32'hDEADBEEF;

    repeat (3) @(posedge clk); #1;
    chk("rst_araddr", mem_axi.araddr, 32'h0);
    chk("rst_awaddr", mem_axi.awaddr, 32'h0);
    chk("rst_wdata", mem_axi.wdata, 32'h0);
    chkb("rst_rready", mem_axi.rready, 1'b0);
    chkb("rst_bready", mem_axi.bready, 1'b0);
    resetn = 1;
    repeat (2) @(posedge clk);

    // single word
    d0 = done_cnt;
    start_copy(32'h3000_0000, 32'h4000_0000, 1);
    wait_done(d0);
    chk("t1_wkmem0", wkmem[0], 32'hDEADBEEF);
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // sixteen words
    d0 = done_cnt;
    start_copy(32'h3000_0040, 32'h4000_0100, 16);
    wait_done(d0);
    for (int k = 0; k < 16; k++) chk("t2_word", wkmem[8'h40 + k], wdmem[8'h10 + k]);
    chk("t2_first", wkmem[8'h40], 32'h1000_0010);
    chk("t2_last", wkmem[8'h4F], 32'h1000_001F);
    chk("t2_after_end", wkmem[8'h50], 32'hFFFF_0050);

    // zero length
    d0 = done_cnt; w0 = wr_cnt;
    start_copy(32'h3000_0000, 32'h4000_0000, 0);
    wait_done(d0);
    repeat (5) @(posedge clk);
    chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t3_no_writes", 32'(wr_cnt - w0), 32'd0);

    // start ignored while busy
    d0 = done_cnt; w0 = wr_cnt;
    start_copy(32'h3000_0080, 32'h4000_0300, 8);
    repeat (3) @(posedge clk);
    pulse_start(32'h3000_0000, 32'h4000_0000, 3);
    repeat (4) @(posedge clk);
    pulse_start(32'h3000_0000, 32'h4000_0000, 0);
    wait_done(d0);
    repeat (10) @(posedge clk);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd8);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
    for (int k = 0; k < 8; k++) chk("t4_word", wkmem[8'hC0 + k], wdmem[8'h20 + k]);
    chk("t4_first", wkmem[8'hC0], 32'h1000_0020);

    // random slave stalls, unaligned start addresses
    stall_en = 1;
    d0 = done_cnt;
    start_copy(32'h3000_0103, 32'h4000_0382, 12);
    wait_done(d0);
    stall_en = 0;
    for (int k = 0; k < 12; k++) chk("t5_word", wkmem[8'hE0 + k], wdmem[8'h40 + k]);
    chk("t5_first", wkmem[8'hE0], 32'h1000_0040);
    chk("t5_before_start", wkmem[8'hDF], 32'hFFFF_00DF);

    // reset in the middle of a copy
    d0 = done_cnt; w0 = wr_cnt;
    start_copy(32'h3000_0200, 32'h4000_0200, 10);
    for (i = 0; i < 2000 && wr_cnt < w0 + 3; i++) @(posedge clk);
    chk("t6_three_written", 32'(wr_cnt - w0), 32'd3);
    @(posedge clk); #2;
    resetn = 0;
    #1;
    chkb("t6_arvalid", mem_axi.arvalid, 1'b0);
    chkb("t6_awvalid", mem_axi.awvalid, 1'b0);
    chkb("t6_wvalid", mem_axi.wvalid, 1'b0);
    chkb("t6_rready", mem_axi.rready, 1'b0);
    chkb("t6_bready", mem_axi.bready, 1'b0);
    chkb("t6_busy", busy, 1'b0);
    repeat (3) @(posedge clk); #1;
    resetn = 1;
    repeat (6) @(posedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    for (int k = 0; k < 3; k++)  chk("t6_copied", wkmem[8'h80 + k], wdmem[8'h80 + k]);
    for (int k = 3; k < 10; k++) chk("t6_untouched", wkmem[8'h80 + k], 32'hFFFF_0080 | 32'(k));

    // recovery after reset
    d0 = done_cnt;
    start_copy(32'h3000_0000, 32'h4000_0010, 2);
    wait_done(d0);
    chk("t6_recover0", wkmem[4], 32'hDEADBEEF);
    chk("t6_recover1", wkmem[5], 32'h1000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
